// File: rtl/hub75_scan_scheduler.sv
// HUB75 binary-coded-modulation scan sequencer: walks (row, plane) loads MSB plane first and
// drives blank/latch/row-select so each plane is shown for BASE_ON << plane cycles.
module hub75_scan_scheduler #(
  parameter int unsigned ROW_W   = 5,
  parameter int unsigned BITS    = 5,
  parameter int unsigned BASE_ON = 6,
  localparam int unsigned PLANE_W = (BITS > 1) ? $clog2(BITS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  output logic               o_shift_start,
  input  logic               i_shift_done,
  output logic [ROW_W-1:0]   o_load_row,
  output logic [PLANE_W-1:0] o_load_plane,
  output logic [ROW_W-1:0]   o_row_select,
  output logic [PLANE_W-1:0] o_plane,
  output logic               o_blank,
  output logic               o_latch,
  output logic               o_frame_done
);

  localparam int unsigned OnMax = BASE_ON << (BITS - 1);
  localparam int unsigned CntW  = $clog2(OnMax + 1);
  localparam logic [PLANE_W-1:0] PlaneTop = PLANE_W'(BITS - 1);
  localparam logic [CntW-1:0]    BaseOn   = CntW'(BASE_ON);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWaitOn,
    StLatch,
    StUnlatch,
    StUnblank
  } state_e;

  state_e             state_q, state_d;
  logic               shift_start_q, shift_start_d;
  logic [ROW_W-1:0]   load_row_q, load_row_d;
  logic [PLANE_W-1:0] load_plane_q, load_plane_d;
  logic [ROW_W-1:0]   row_sel_q, row_sel_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic               blank_q, blank_d;
  logic               latch_q, latch_d;
  logic               frame_done_q, frame_done_d;
  logic [CntW-1:0]    on_cnt_q, on_cnt_d;

  always_comb begin
    state_d       = state_q;
    shift_start_d = 1'b0;
    load_row_d    = load_row_q;
    load_plane_d  = load_plane_q;
    row_sel_d     = row_sel_q;
    plane_d       = plane_q;
    blank_d       = blank_q;
    latch_d       = latch_q;
    frame_done_d  = 1'b0;
    on_cnt_d      = on_cnt_q;

    // On-time counter runs free of the FSM; the panel goes dark as it expires.
    if (on_cnt_q != '0) begin
      on_cnt_d = on_cnt_q - 1'b1;
      if (on_cnt_q == CntW'(1)) begin
        blank_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          shift_start_d = 1'b1;
          state_d       = StShift;
        end
      end
      StShift: begin
        if (i_shift_done) begin
          state_d = StWaitOn;
        end
      end
      StWaitOn: begin
        if (on_cnt_q == '0) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        blank_d   = 1'b1;
        latch_d   = 1'b1;
        row_sel_d = load_row_q;
        plane_d   = load_plane_q;
        state_d   = StUnlatch;
      end
      StUnlatch: begin
        latch_d    = 1'b0;
        load_row_d = load_row_q + 1'b1;
        if (load_row_q == '1) begin
          if (load_plane_q == '0) begin
            load_plane_d = PlaneTop;
            frame_done_d = 1'b1;
          end else begin
            load_plane_d = load_plane_q - 1'b1;
          end
        end
        state_d = StUnblank;
      end
      StUnblank: begin
        blank_d  = 1'b0;
        on_cnt_d = BaseOn << plane_q;
        if (i_enable) begin
          shift_start_d = 1'b1;
          state_d       = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      shift_start_q <= 1'b0;
      load_row_q    <= '0;
      load_plane_q  <= PlaneTop;
      row_sel_q     <= '0;
      plane_q       <= PlaneTop;
      blank_q       <= 1'b1;
      latch_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      on_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      shift_start_q <= shift_start_d;
      load_row_q    <= load_row_d;
      load_plane_q  <= load_plane_d;
      row_sel_q     <= row_sel_d;
      plane_q       <= plane_d;
      blank_q       <= blank_d;
      latch_q       <= latch_d;
      frame_done_q  <= frame_done_d;
      on_cnt_q      <= on_cnt_d;
    end
  end

  assign o_shift_start = shift_start_q;
  assign o_load_row    = load_row_q;
  assign o_load_plane  = load_plane_q;
  assign o_row_select  = row_sel_q;
  assign o_plane       = plane_q;
  assign o_blank       = blank_q;
  assign o_latch       = latch_q;
  assign o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Scoreboard bench for hub75_scan_scheduler: expected loads/latches/on-times come from a
// frame-order model; a monitor pops and compares as the DUT produces each event.
module tb_hub75_scan_scheduler;

  localparam int ROW_W   = 5;
  localparam int BITS    = 5;
  localparam int BASE_ON = 6;
  localparam int ROWS    = 1 << ROW_W;
  localparam int FRAME   = ROWS * BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             shift_done = 1'b0;
  logic             shift_start, blank, latch, frame_done;
  logic [ROW_W-1:0] load_row, row_select;
  logic [2:0]       load_plane, plane;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hub75_scan_scheduler #(
    .ROW_W   (ROW_W),
    .BITS    (BITS),
    .BASE_ON (BASE_ON)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .o_shift_start (shift_start),
    .i_shift_done  (shift_done),
    .o_load_row    (load_row),
    .o_load_plane  (load_plane),
    .o_row_select  (row_select),
    .o_plane       (plane),
    .o_blank       (blank),
    .o_latch       (latch),
    .o_frame_done  (frame_done)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame order: planes MSB..LSB, rows ascending within each plane.
  function automatic int model_row(input int k);
    return k % ROWS;
  endfunction

  function automatic int model_plane(input int k);
    return BITS - 1 - ((k / ROWS) % BITS);
  endfunction

  int exp_load_q[$];
  int exp_latch_q[$];
  int exp_width_q[$];

  task automatic sb_reset();
    exp_load_q.delete();
    exp_latch_q.delete();
    exp_width_q.delete();
    for (int k = 0; k < 400; k++) begin
      exp_load_q.push_back(model_row(k) * 16 + model_plane(k));
      exp_latch_q.push_back(model_row(k) * 16 + model_plane(k));
      exp_width_q.push_back(BASE_ON << model_plane(k));
    end
  endtask

  // Monitor state
  int lat_cnt = 0;
  int start_cnt = 0;
  int fd_cnt = 0;
  int low_len = 0;
  int cyc = 0;
  int last_rise = 0;
  bit prev_latch = 1'b0;
  bit prev_blank = 1'b1;
  bit seen_rise = 1'b0;

  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        sb_reset();
        lat_cnt    = 0;
        fd_cnt     = 0;
        prev_latch = 1'b0;
        prev_blank = 1'b1;
        seen_rise  = 1'b0;
        low_len    = 0;
        continue;
      end
      if (shift_start) begin
        start_cnt++;
        if (exp_load_q.size() == 0) check("start_underflow", 1, 0);
        else begin
          e = exp_load_q.pop_front();
          check("start_load_row16_plane", int'(load_row) * 16 + int'(load_plane), e);
        end
      end
      if (prev_latch) begin
        check("frame_done_after_latch", int'(frame_done),
              int'(((lat_cnt - 1) % FRAME) == FRAME - 1));
      end else if (frame_done) begin
        check("frame_done_spurious", 1, 0);
      end
      if (frame_done) begin
        fd_cnt++;
        check("wrap_load_row", int'(load_row), 0);
        check("wrap_load_plane", int'(load_plane), BITS - 1);
      end
      if (latch) begin
        check("latch_in_blank", int'(blank), 1);
        check("latch_one_cycle", int'(prev_latch), 0);
        if (exp_latch_q.size() == 0) check("latch_underflow", 1, 0);
        else begin
          e = exp_latch_q.pop_front();
          check("latch_row16_plane", int'(row_select) * 16 + int'(plane), e);
        end
        lat_cnt++;
      end
      prev_latch = latch;
      if (!blank) begin
        if (prev_blank) begin
          if (seen_rise) check("blank_gap_ge4", int'((cyc - last_rise) >= 4), 1);
          low_len = 0;
        end
        low_len++;
      end else if (!prev_blank) begin
        if (exp_width_q.size() == 0) check("width_underflow", 1, 0);
        else begin
          e = exp_width_q.pop_front();
          check("blank_low_width", low_len, e);
        end
        last_rise = cyc;
        seen_rise = 1'b1;
      end
      prev_blank = blank;
    end
  end

  // Shifter model: done a chosen delay after each start, optional stray dones while waiting.
  int fixed_delay = 10;
  bit stray_en = 1'b0;
  bit sh_busy = 1'b0;
  bit sh_wait = 1'b0;
  int sh_cnt = 0;
  int strays = 0;

  initial begin
    forever begin
      @(negedge clk);
      shift_done = 1'b0;
      if (rst) begin
        sh_busy = 1'b0;
        sh_wait = 1'b0;
        continue;
      end
      if (latch) sh_wait = 1'b0;
      if (sh_busy) begin
        if (sh_cnt == 0) begin
          shift_done = 1'b1;
          sh_busy    = 1'b0;
          sh_wait    = 1'b1;
        end else begin
          sh_cnt--;
        end
      end else if (sh_wait && stray_en && $urandom_range(0, 3) == 0) begin
        shift_done = 1'b1;
        strays++;
      end
      if (shift_start) begin
        check("start_after_prev_done", int'(sh_busy), 0);
        sh_busy = 1'b1;
        if (fixed_delay >= 0) sh_cnt = fixed_delay;
        else if ($urandom_range(0, 7) == 0) sh_cnt = 200;
        else sh_cnt = $urandom_range(1, 40);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_blank"}, int'(blank), 1);
    check({tag, "_latch"}, int'(latch), 0);
    check({tag, "_start"}, int'(shift_start), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_row_select"}, int'(row_select), 0);
    check({tag, "_load_row"}, int'(load_row), 0);
    check({tag, "_plane"}, int'(plane), BITS - 1);
    check({tag, "_load_plane"}, int'(load_plane), BITS - 1);
  endtask

  task automatic wait_latches(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (lat_cnt < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (lat_cnt < n) check({name, "_timeout"}, lat_cnt, n);
  endtask

  initial begin
    int t;
    int s0;
    int l0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");

    // First rows with a fixed 10-cycle shifter, then a randomized run past a frame wrap.
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    wait_latches(2, 2000, "first_rows");
    fixed_delay = -1;
    stray_en    = 1'b1;
    wait_latches(FRAME + 5, 40000, "frame_run");
    check("frame_done_count", fd_cnt, 1);

    // Slow shifter, enable dropped while the shifter is loading.
    stray_en    = 1'b0;
    fixed_delay = 200;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!shift_start && t < 2000);
    check("disable_start_seen", int'(shift_start), 1);
    enable = 1'b0;
    s0 = start_cnt;
    l0 = lat_cnt;
    repeat (600) @(negedge clk);
    check("disable_no_start", start_cnt, s0);
    check("disable_row_completed", lat_cnt, l0 + 1);
    check("disable_idle_blank", int'(blank), 1);

    // Resume, then reset while the latch pulse is high.
    fixed_delay = 5;
    enable      = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!latch && t < 2000);
    check("unlatch_latch_seen", int'(latch), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("reset_unlatch");
    @(negedge clk);
    rst         = 1'b0;
    fixed_delay = -1;
    wait_latches(3, 4000, "after_reset");
    enable = 1'b0;
    repeat (400) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
